// File: rtl/join_vector.sv
// rtl/join_vector.sv - reassembles beat-serial lane results into one vector for writeback
//
// Purpose: collects S beats of L lane results and stores lane k, beat b at
// element k*S+b (inverse of the fork stage). When the last beat has been
// captured it raises a one-cycle write strobe carrying the destination
// register address that was latched at issue.
//
// Ports:
//   CLK           clock, posedge active
//   RST           asynchronous active-high reset
//   Start_i       vector op issue pulse, latches Dest_i (IDLE or DONE only)
//   Dest_i        destination vector register address
//   Lane_Valid_i  Lane_Res_i carries a valid beat (used in COLLECT only)
//   Lane_Res_i    lane results, lane k at index k
//   Result_VEC_o  assembled result vector (registered)
//   WD_Addr_o     latched destination address
//   WE_o          one-cycle writeback strobe (state DONE)
//   Busy_o        high while collecting beats
//   Beat_o        index of the next beat to be captured, 0..S-1
module join_vector #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4,
  parameter int S = 5,
  parameter int A = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start_i,
  input  logic [A-1:0]          Dest_i,
  input  logic                  Lane_Valid_i,
  input  logic [L-1:0][N-1:0]   Lane_Res_i,
  output logic [V-1:0][N-1:0]   Result_VEC_o,
  output logic [A-1:0]          WD_Addr_o,
  output logic                  WE_o,
  output logic                  Busy_o,
  output logic [2:0]            Beat_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(S - 1);

  state_t               state_q, state_d;
  logic [2:0]           beat_q, beat_d;
  logic [V-1:0][N-1:0]  vec_q, vec_d;
  logic [A-1:0]         addr_q, addr_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      vec_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vec_d   = vec_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        if (Start_i) begin
          addr_d  = Dest_i;
          beat_d  = '0;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (Lane_Valid_i) begin
          // Compare against every beat index so all element selects are
          // constant; only the column for the current beat is written.
          for (int k = 0; k < L; k++) begin
            for (int b = 0; b < S; b++) begin
              if (beat_q == 3'(b)) begin
                vec_d[k*S + b] = Lane_Res_i[k];
              end
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      DONE: begin
        // A new issue here goes straight back to COLLECT without an IDLE gap.
        if (Start_i) begin
          addr_d  = Dest_i;
          beat_d  = '0;
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign Result_VEC_o = vec_q;
  assign WD_Addr_o    = addr_q;
  assign WE_o         = (state_q == DONE);
  assign Busy_o       = (state_q == COLLECT);
  assign Beat_o       = beat_q;

endmodule

// File: tb/tb_join_vector.sv
// tb/tb_join_vector.sv - self-checking bench for join_vector
module tb_join_vector;
  localparam int N = 32;
  localparam int V = 20;
  localparam int L = 4;
  localparam int S = 5;
  localparam int A = 4;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  Start_i = 1'b0;
  logic [A-1:0]          Dest_i = '0;
  logic                  Lane_Valid_i = 1'b0;
  logic [L-1:0][N-1:0]   Lane_Res_i = '0;
  logic [V-1:0][N-1:0]   Result_VEC_o;
  logic [A-1:0]          WD_Addr_o;
  logic                  WE_o;
  logic                  Busy_o;
  logic [2:0]            Beat_o;

  join_vector #(.N(N), .V(V), .L(L), .S(S), .A(A)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Start_i      (Start_i),
    .Dest_i       (Dest_i),
    .Lane_Valid_i (Lane_Valid_i),
    .Lane_Res_i   (Lane_Res_i),
    .Result_VEC_o (Result_VEC_o),
    .WD_Addr_o    (WD_Addr_o),
    .WE_o         (WE_o),
    .Busy_o       (Busy_o),
    .Beat_o       (Beat_o)
  );

  always #5 CLK = ~CLK;

  typedef logic [L-1:0][N-1:0] lanes_t;
  typedef logic [V-1:0][N-1:0] vec_t;

  // One record per clock cycle: inputs to apply, plus what must be visible
  // on the outputs just before they are applied.
  typedef struct {
    logic         start;
    logic [A-1:0] dest;
    logic         valid;
    lanes_t       res;
    int           exp_beat;
    int           exp_busy;
    logic [A-1:0] exp_addr;
    logic         chk_vec;
    vec_t         vec;
  } cyc_t;

  typedef struct {
    int           idx;
    logic [A-1:0] dest;
    vec_t         vec;
  } we_t;

  typedef struct {
    logic [A-1:0] dest;
    int           stall_beat;
    int           stall_len;
    int           gap;
    bit           junk;
    int           base;
    int           exp_cycles;
    logic [N-1:0] e0;
    logic [N-1:0] e7;
    logic [N-1:0] e19;
  } row_t;

  cyc_t         stim[$];
  we_t          exp_q[$];
  we_t          obs_q[$];
  vec_t         model_vec = '0;
  logic [A-1:0] model_addr = '0;
  int           checks = 0;
  int           errors = 0;

  row_t         rows[4];
  int           starts[4];
  lanes_t       dat[S];
  int           dummy_start;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t r;
    for (int k = 0; k < L; k++) r[k] = $urandom;
    return r;
  endfunction

  task automatic push(input logic start, input logic [A-1:0] dest, input logic valid,
                      input lanes_t res, input int exp_beat, input int exp_busy,
                      input logic chk);
    cyc_t c;
    c.start    = start;
    c.dest     = dest;
    c.valid    = valid;
    c.res      = res;
    c.exp_beat = exp_beat;
    c.exp_busy = exp_busy;
    c.exp_addr = model_addr;
    c.chk_vec  = chk;
    c.vec      = model_vec;
    stim.push_back(c);
  endtask

  task automatic push_idle(input bit junk);
    lanes_t dead;
    for (int k = 0; k < L; k++) dead[k] = 32'h0000DEAD;
    push(1'b0, 4'h7, junk, dead, -1, 0, 1'b1);
  endtask

  // Reference: a vector op is one start cycle, S captured beats, optional
  // stall cycles, and the strobe in the cycle after the last capture.
  task automatic add_op(input logic [A-1:0] dest, input lanes_t data[S], input int stall_beat,
                        input int stall_len, input bit junk, output int s);
    int     t;
    lanes_t dead;
    t = 0;
    for (int k = 0; k < L; k++) dead[k] = 32'h0000DEAD;
    s = stim.size();
    push(1'b1, dest, junk, dead, -1, 0, 1'b1);
    model_addr = dest;
    for (int b = 0; b < S; b++) begin
      if (b == stall_beat) begin
        for (int j = 0; j < stall_len; j++) begin
          push(junk, 4'h7, 1'b0, rand_lanes(), b, 1, 1'b0);
          t++;
        end
      end
      push(junk, 4'h7, 1'b1, data[b], b, 1, 1'b0);
    end
    for (int b = 0; b < S; b++)
      for (int k = 0; k < L; k++)
        model_vec[k*S + b] = data[b][k];
    exp_q.push_back('{s + S + t + 1, dest, model_vec});
  endtask

  task automatic run_stim();
    int ep;
    ep = 0;
    obs_q.delete();
    foreach (stim[i]) begin
      @(negedge CLK);
      if (WE_o) obs_q.push_back('{i, WD_Addr_o, Result_VEC_o});
      if (ep < exp_q.size() && exp_q[ep].idx == i) begin
        check("we_strobe", 64'(WE_o), 64'd1);
        check("we_addr", 64'(WD_Addr_o), 64'(exp_q[ep].dest));
        checkv("we_vector", Result_VEC_o, exp_q[ep].vec);
        ep++;
      end else begin
        check("we_quiet", 64'(WE_o), 64'd0);
      end
      if (stim[i].exp_beat >= 0) check("beat", 64'(Beat_o), 64'(stim[i].exp_beat));
      check("busy", 64'(Busy_o), 64'(stim[i].exp_busy));
      check("addr_hold", 64'(WD_Addr_o), 64'(stim[i].exp_addr));
      if (stim[i].chk_vec) checkv("vec_hold", Result_VEC_o, stim[i].vec);
      Start_i      = stim[i].start;
      Dest_i       = stim[i].dest;
      Lane_Valid_i = stim[i].valid;
      Lane_Res_i   = stim[i].res;
    end
    check("we_count", 64'(ep), 64'(exp_q.size()));
    stim.delete();
    exp_q.delete();
  endtask

  initial begin
    rows[0] = '{4'h3, -1, 0, 1, 1'b0, 0,    7, 32'd0,    32'd102,  32'd304};
    rows[1] = '{4'h3,  3, 2, 2, 1'b0, 0,    9, 32'd0,    32'd102,  32'd304};
    rows[2] = '{4'hA, -1, 0, 0, 1'b0, 1000, 7, 32'd1000, 32'd1102, 32'd1304};
    rows[3] = '{4'h5,  1, 1, 2, 1'b1, 2000, 8, 32'd2000, 32'd2102, 32'd2304};

    // Reset state
    repeat (2) @(negedge CLK);
    checkv("rst_vec", Result_VEC_o, '0);
    check("rst_addr", 64'(WD_Addr_o), 64'd0);
    check("rst_we", 64'(WE_o), 64'd0);
    check("rst_busy", 64'(Busy_o), 64'd0);
    check("rst_beat", 64'(Beat_o), 64'd0);
    RST = 1'b0;

    // Table-driven ops: basic, stall, back-to-back, ignored inputs
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < rows[r].gap; g++) push_idle(rows[r].junk);
      for (int b = 0; b < S; b++)
        for (int k = 0; k < L; k++)
          dat[b][k] = N'(rows[r].base + 100 * k + b);
      add_op(rows[r].dest, dat, rows[r].stall_beat, rows[r].stall_len, rows[r].junk, starts[r]);
    end
    push_idle(1'b1);
    push_idle(1'b1);
    push_idle(1'b0);
    run_stim();
    for (int r = 0; r < 4; r++) begin
      if (r < obs_q.size()) begin
        check("tbl_cycles", 64'(obs_q[r].idx - starts[r] + 1), 64'(rows[r].exp_cycles));
        check("tbl_addr", 64'(obs_q[r].dest), 64'(rows[r].dest));
        check("tbl_e0", 64'(obs_q[r].vec[0]), 64'(rows[r].e0));
        check("tbl_e7", 64'(obs_q[r].vec[7]), 64'(rows[r].e7));
        check("tbl_e19", 64'(obs_q[r].vec[19]), 64'(rows[r].e19));
      end else begin
        checks++;
        errors++;
        $display("FAIL tbl_missing_we: got no strobe expected one for row %0d", r);
      end
    end

    // Abort: asynchronous reset after beat 2
    @(negedge CLK);
    Start_i = 1'b1; Dest_i = 4'h9; Lane_Valid_i = 1'b0;
    @(negedge CLK);
    Start_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      Lane_Valid_i = 1'b1;
      Lane_Res_i   = rand_lanes();
      @(negedge CLK);
    end
    Lane_Valid_i = 1'b0;
    check("abort_beat", 64'(Beat_o), 64'd3);
    check("abort_busy", 64'(Busy_o), 64'd1);
    #2 RST = 1'b1;
    #1;
    checkv("abort_vec", Result_VEC_o, '0);
    check("abort_addr", 64'(WD_Addr_o), 64'd0);
    check("abort_we", 64'(WE_o), 64'd0);
    check("abort_busy0", 64'(Busy_o), 64'd0);
    check("abort_beat0", 64'(Beat_o), 64'd0);
    @(negedge CLK);
    check("abort_we_hold", 64'(WE_o), 64'd0);
    RST = 1'b0;
    model_vec  = '0;
    model_addr = '0;
    for (int b = 0; b < S; b++) dat[b] = rand_lanes();
    add_op(4'hC, dat, -1, 0, 1'b0, dummy_start);
    push_idle(1'b0);
    push_idle(1'b0);
    run_stim();

    // Randomized ops against the reference
    for (int op = 0; op < 12; op++) begin
      int gap;
      int sb;
      int sl;
      bit jk;
      gap = int'($urandom_range(0, 2));
      sb  = int'($urandom_range(0, 5));
      sl  = (sb == 5) ? 0 : int'($urandom_range(0, 3));
      jk  = bit'($urandom_range(0, 1));
      for (int g = 0; g < gap; g++) push_idle(jk);
      for (int b = 0; b < S; b++) dat[b] = rand_lanes();
      add_op(4'($urandom), dat, sb, sl, jk, dummy_start);
    end
    push_idle(1'b1);
    push_idle(1'b1);
    run_stim();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/join_vector.md
Name: join_vector

Overview:
- Downstream of the vector fork stage: reassembles 4-lane ALU results, produced over 5 beats, into one V-element result vector for register-file writeback.
- Sits between the 4 parallel lane ALUs and the vector register-file write port.
- Lane k, beat b maps to element k*S + b, the inverse of the fork mapping.
- Issues a one-cycle write strobe with the captured destination address once all beats are in.

Parameters:
N, 32, element width in bits
V, 20, elements per vector
L, 4, parallel lanes
S, 5, beats per vector (V/L; V must equal L*S)
A, 4, destination register address width

Ports:
CLK  in  1  clock, posedge active
RST  in  1  asynchronous active-high reset
Start_i  in  1  vector op issue pulse; latches Dest_i
Dest_i  in  A  destination vector register address
Lane_Valid_i  in  1  Lane_Res_i holds a valid beat this cycle
Lane_Res_i  in  [L][N]  lane results, lane k at index k
Result_VEC_o  out  [V][N]  assembled result vector (registered)
WD_Addr_o  out  A  latched destination address
WE_o  out  1  one-cycle writeback strobe
Busy_o  out  1  high in COLLECT
Beat_o  out  3  current beat index 0..S-1

Behaviour:
- Reset, asynchronous on RST rising and held while high: state IDLE, beat=0, Result_VEC_o all 0, WD_Addr_o=0, WE_o=0, Busy_o=0, Beat_o=0.
- All state updates occur on the CLK posedge.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - Start_i=1: latch Dest_i into WD_Addr_o, set beat=0, go to COLLECT.
  - Lane_Valid_i is ignored, with no capture.
- COLLECT:
  - Lane_Valid_i=1: for each k in 0..L-1, Result_VEC_o[k*S+beat] <= Lane_Res_i[k].
  - If beat==S-1, set beat=0 and go to DONE; otherwise increment beat.
  - Lane_Valid_i=0: stall, with no capture and beat held.
  - Start_i is ignored (no re-latch of Dest_i).
- DONE:
  - WE_o=1 for exactly this one cycle; Result_VEC_o holds a complete vector.
  - Next state is COLLECT if Start_i=1 (latch new Dest_i, beat=0), else IDLE.
  - Lane_Valid_i in DONE is ignored.
- Output decode:
  - WE_o is a registered state decode (WE_o = state==DONE).
  - Busy_o = state==COLLECT.
  - Beat_o = beat.
- Latency: the final capture edge is followed by WE_o high in the next cycle. An unstalled vector takes 1 (start) + 5 (beats) + 1 (DONE) = 7 cycles from Start_i to the WE_o cycle.
- Result_VEC_o is not cleared on Start_i. Elements hold their previous value until overwritten, and persist after DONE until the next capture or reset.
- Reset mid-COLLECT aborts: no WE_o, vector zeroed, state IDLE.
- Beat counter never exceeds S-1. Wrap to 0 only on the final capture.
- No arithmetic on data. Data is stored bit-exact, N bits per element, with no sign handling.

Test Plan:
- Reset, then check that RST=1 asynchronously clears everything.
  - Stimulus: mid-cycle RST=1.
  - Response: all outputs 0 immediately, before the next CLK edge.
- Basic assemble.
  - Stimulus: Start_i with Dest_i=4'h3; then 5 consecutive valid beats with Lane_Res_i[k]=100*k+b.
  - Response: WE_o high exactly one cycle later, WD_Addr_o=3, and Result_VEC_o[k*5+b]=100*k+b for all 20 elements (e.g. [0]=0, [7]=102, [19]=304).
- Stall.
  - Stimulus: same data with Lane_Valid_i=0 for 2 cycles between beats 2 and 3.
  - Response: Beat_o holds at 3 during the stall; WE_o asserts 2 cycles later than in the basic case; result identical to the basic case.
- Back-to-back.
  - Stimulus: Start_i asserted in the DONE cycle with Dest_i=4'hA.
  - Response: returns to COLLECT with no IDLE cycle; second WE_o has WD_Addr_o=A. WD_Addr_o stays 3 through the first DONE cycle and changes to A on the edge that leaves DONE.
- Ignored inputs.
  - Stimulus: Lane_Valid_i=1 with data 32'hDEAD in IDLE; Start_i pulsed mid-COLLECT with Dest_i=4'h7.
  - Response: no element changes in IDLE; WD_Addr_o unchanged; beat count unaffected.
- Abort.
  - Stimulus: RST=1 after beat 2 of a vector.
  - Response: no WE_o, Result_VEC_o=0, state IDLE. A subsequent full vector completes correctly.
